led_pad_driver: RTL
===================

// Module: led_pad_driver
// PURPOSE
//  Downstream stage of the memory-mapped LED register: consumes its 17-bit word (bit16 = "no data
//  written since reset", bits15:0 = pattern) and drives the 16 board LED pads. Shows a rotating
//  chase while no data is present, a short all-on flash when data first arrives, then the pattern.
//  Optional brightness PWM. Sits between the LED register and the top-level pad ports.
// PARAMETERS
//  PRESC_DIV    5_000_000  led_clk cycles per tick (>=2); tick paces chase and flash
//  FLASH_TICKS  4          ticks of all-on flash on CHASE->SHOW entry (>=1)
// PORTS
//  led_clk    in   1   clock, rising edge (LED register updates on falling edge)
//  ledrst     in   1   reset
//  led_in     in   17  LED register word: [16] no-data flag, [15:0] pattern
//  bright     in   3   brightness level 0..7 (used only with LED_PWM_EN)
//  led_pad    out  16  LED pad drive, 1 = lit
//  led_alive  out  1   1 when a CPU-written pattern is being shown (FLASH or SHOW)
// BEHAVIOUR
//  - Reset ledrst, asynchronous, active-high: led_pad=16'h0000, led_alive=0, state=CHASE,
//    chase_pos=0, tick counter=0, flash counter=0, pwm_cnt=0, led_q=17'h10000.
//  - led_in sampled into led_q on every rising edge; all decisions use led_q. led_pad/led_alive
//    are registers loaded from next-state values -> led_in change visible on 2nd rising edge.
//  - Tick: counter 0..PRESC_DIV-1, tick pulse when at PRESC_DIV-1; counter cleared on every
//    state transition, so first tick in a new state comes exactly PRESC_DIV cycles after entry.
//  - States: CHASE, FLASH, SHOW.
//    CHASE: raw = 16'h1 << chase_pos; chase_pos +1 per tick, 15 wraps to 0. led_q[16]=0 -> FLASH.
//    FLASH: raw = 16'hFFFF for FLASH_TICKS ticks (FLASH_TICKS*PRESC_DIV cycles), then SHOW.
//    SHOW : raw = led_q[15:0]; pattern changes pass through with no flash.
//    From FLASH or SHOW, led_q[16]=1 -> CHASE next edge, chase_pos reset to 0 (wins over a
//    coincident tick or flash completion). Entering CHASE always starts at 16'h0001.
//  - led_alive = 1 in FLASH/SHOW, 0 in CHASE (registered with state).
//  - led_pad = raw & {16{lit}}; lit defined under CONFIGURATION.
//  - ledrst mid-operation: immediate return to reset values, chase restarts from 0001.
// CONFIGURATION
//  LED_PWM_EN defined: 3-bit pwm_cnt free-runs 0..7 (wraps); lit = (pwm_cnt <= bright), i.e.
//    duty (bright+1)/8; bright=7 always lit, bright=0 lit only when pwm_cnt==0. bright sampled
//    combinationally each cycle, no sync needed (switch input, glitch tolerant).
//  LED_PWM_EN undefined: no pwm_cnt register, bright ignored, lit = 1.
// STRUCTURE
//  - Package led_pkg: LED_N=16, state encoding ST_CHASE=2'd0, ST_FLASH=2'd1, ST_SHOW=2'd2,
//    LED_IDLE_WORD=17'h10000.
//  - Sub-module led_tick_gen (params PRESC_DIV; ports clk, rst, clr, tick): prescaler with
//    synchronous clear, width $clog2(PRESC_DIV). FSM, chase, flash count, PWM stay in top.
// TESTING (bench overrides PRESC_DIV=4, FLASH_TICKS=2; LED_PWM_EN defined unless stated)
//  1 Reset held, led_in=17'h10000, bright=7 -> led_pad=0000, alive=0; after release chase
//    0001,0002,...,8000,0001 one step per 4 cycles, alive=0 throughout.
//  2 In CHASE drive led_in=17'h0A5A5 -> 2nd edge: led_pad=FFFF, alive=1 for 8 cycles, then A5A5.
//  3 SHOW, led_in=17'h0FFFF, bright=0 -> led_pad=FFFF 1 of every 8 cycles else 0000; bright=3
//    -> 4 of 8; rebuild without LED_PWM_EN -> constant FFFF for any bright.
//  4 During FLASH (cycle 3 of 8) drive led_in=17'h10000 -> 2nd edge: led_pad=0001, alive=0,
//    next step to 0002 exactly 4 cycles later.
//  5 SHOW A5A5, change led_in to 17'h01234 -> 2nd edge led_pad=1234, no flash, alive stays 1.
//  6 Assert ledrst mid-SHOW between edges -> led_pad=0000, alive=0 immediately; after release
//    with led_in=17'h10000 chase restarts at 0001.

Source files
------------

// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared constants and state encoding for the LED pad driver
package led_pkg;

  localparam int LED_N = 16;

  typedef enum logic [1:0] {
    ST_CHASE = 2'd0,
    ST_FLASH = 2'd1,
    ST_SHOW  = 2'd2
  } led_state_t;

  localparam logic [LED_N:0] LED_IDLE_WORD = 17'h10000;

endpackage

// File: rtl/led_pad_driver_tick_gen.sv
// rtl/led_pad_driver_tick_gen.sv - led_tick_gen: prescaler that pulses tick once every PRESC_DIV cycles
module led_tick_gen #(
  parameter int PRESC_DIV = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int W = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(PRESC_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/led_pad_driver.sv
// rtl/led_pad_driver.sv - chase/flash/show LED pad driver; LED_PWM_EN adds brightness PWM
module led_pad_driver
  import led_pkg::*;
#(
  parameter int PRESC_DIV   = 5_000_000,
  parameter int FLASH_TICKS = 4
) (
  input  logic             led_clk,
  input  logic             ledrst,
  input  logic [LED_N:0]   led_in,
  input  logic [2:0]       bright,
  output logic [LED_N-1:0] led_pad,
  output logic             led_alive
);

  localparam int FW = $clog2(FLASH_TICKS + 1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_TICKS - 1);

  logic [LED_N:0]   led_q;
  led_state_t       state, state_nxt;
  logic [3:0]       chase_pos, chase_nxt;
  logic [FW-1:0]    flash_cnt, flash_nxt;
  logic [LED_N-1:0] raw_nxt;
  logic             tick;
  logic             clr;
  logic             lit;

  led_tick_gen #(.PRESC_DIV(PRESC_DIV)) u_tick (
    .clk  (led_clk),
    .rst  (ledrst),
    .clr  (clr),
    .tick (tick)
  );

  always_ff @(posedge led_clk or posedge ledrst) begin
    if (ledrst) begin
      led_q     <= LED_IDLE_WORD;
      state     <= ST_CHASE;
      chase_pos <= '0;
      flash_cnt <= '0;
      led_pad   <= '0;
      led_alive <= 1'b0;
    end else begin
      led_q     <= led_in;
      state     <= state_nxt;
      chase_pos <= chase_nxt;
      flash_cnt <= flash_nxt;
      led_pad   <= raw_nxt & {LED_N{lit}};
      led_alive <= (state_nxt != ST_CHASE);
    end
  end

  // Loss of data (led_q[16]) overrides any tick or flash completion in the same cycle.
  always_comb begin
    state_nxt = state;
    chase_nxt = chase_pos;
    flash_nxt = flash_cnt;
    case (state)
      ST_CHASE: begin
        if (!led_q[LED_N]) state_nxt = ST_FLASH;
        else if (tick)     chase_nxt = chase_pos + 4'd1;
      end
      ST_FLASH: begin
        if (led_q[LED_N]) begin
          state_nxt = ST_CHASE;
        end else if (tick) begin
          if (flash_cnt == FLASH_LAST) state_nxt = ST_SHOW;
          else                         flash_nxt = flash_cnt + 1'b1;
        end
      end
      ST_SHOW: begin
        if (led_q[LED_N]) state_nxt = ST_CHASE;
      end
      default: state_nxt = ST_CHASE;
    endcase
    // Every state entry starts clean: chase at 0001, flash count at zero.
    if (state_nxt != state) begin
      chase_nxt = '0;
      flash_nxt = '0;
    end
    case (state_nxt)
      ST_CHASE: raw_nxt = LED_N'(1) << chase_nxt;
      ST_FLASH: raw_nxt = '1;
      default:  raw_nxt = led_q[LED_N-1:0];
    endcase
  end

  assign clr = (state_nxt != state);

`ifdef LED_PWM_EN
  logic [2:0] pwm_cnt;

  always_ff @(posedge led_clk or posedge ledrst) begin
    if (ledrst) pwm_cnt <= '0;
    else        pwm_cnt <= pwm_cnt + 3'd1;
  end

  assign lit = (pwm_cnt <= bright);
`else
  logic unused_bright;
  assign unused_bright = ^bright;
  assign lit = 1'b1;
`endif

endmodule
